// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W = 8;

endpackage

// File: rtl/seq_div_step.sv
// div_step: one restoring-division iteration. Shifts the next dividend bit
// into the partial remainder, trial-subtracts the divisor magnitude in
// N+1 bits and keeps or restores depending on the borrow (sign bit).
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_acc,
    input  logic         i_bit,
    input  logic [N-1:0] i_div,
    output logic [N-1:0] o_acc,
    output logic         o_q
);

    logic [N:0] w_shift;
    logic [N:0] w_diff;

    // Trial subtraction; a clear sign bit means the divisor fits.
    always_comb begin
        w_shift = {i_acc, i_bit};
        w_diff  = w_shift - {1'b0, i_div};
        if (!w_diff[N]) begin
            o_acc = w_diff[N-1:0];
            o_q   = 1'b1;
        end else begin
            o_acc = w_shift[N-1:0];
            o_q   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Start/Busy/Done handshake; latency n+1 cycles from the accepting edge to
// the Done cycle regardless of operands.
// Optional build macro SEQ_DIV_SIGNED_EN selects two's-complement operands
// and results (truncating division); undefined gives unsigned division.
//
// Handshake: Start is sampled only while IDLE. The accepting edge latches
// A/B and raises Busy; Done pulses for exactly one cycle with Q/R/DivZero
// already valid, and Busy drops at the edge ending that cycle. Start seen
// while busy is dropped, never queued.
module seq_div
    import div_pkg::*;
#(
    parameter int n = DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         DivZero,
    output logic [1:0]   o_dbg_state
);

    localparam int CW = $clog2(n);

    div_state_t     r_state;
    logic [n-1:0]   r_acc;
    logic [n-1:0]   r_dvd;
    logic [n-1:0]   r_div;
    logic [n-1:0]   r_a;
    logic [CW-1:0]  r_cnt;
    logic           r_bzero;
    logic           r_busy;
    logic           r_done;
    logic [n-1:0]   r_q;
    logic [n-1:0]   r_r;
    logic           r_divzero;
`ifdef SEQ_DIV_SIGNED_EN
    logic           r_neg_q;
    logic           r_neg_r;
`endif

    logic [n-1:0]   w_a_mag;
    logic [n-1:0]   w_b_mag;
    logic [n-1:0]   w_acc;
    logic           w_qbit;
    logic [n-1:0]   w_q_mag;
    logic [n-1:0]   w_q_fin;
    logic [n-1:0]   w_r_fin;

    // Single datapath step shared by every CALC cycle.
    div_step #(.N(n)) u_step (
        .i_acc (r_acc),
        .i_bit (r_dvd[n-1]),
        .i_div (r_div),
        .o_acc (w_acc),
        .o_q   (w_qbit)
    );

    assign w_q_mag = {r_dvd[n-2:0], w_qbit};

    // Operand magnitudes on entry and sign correction of the final step.
    // Most-negative dividend maps to itself, which is its true magnitude
    // read unsigned, so the overflow case needs no special handling.
    always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
        w_a_mag = A[n-1] ? (~A + 1'b1) : A;
        w_b_mag = B[n-1] ? (~B + 1'b1) : B;
        w_q_fin = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
        w_r_fin = r_neg_r ? (~w_acc + 1'b1) : w_acc;
`else
        w_a_mag = A;
        w_b_mag = B;
        w_q_fin = w_q_mag;
        w_r_fin = w_acc;
`endif
        if (r_bzero) begin
            w_q_fin = '1;
            w_r_fin = r_a;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_dvd     <= '0;
            r_div     <= '0;
            r_a       <= '0;
            r_cnt     <= '0;
            r_bzero   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_divzero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a     <= A;
                        r_dvd   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= CW'(n - 1);
                        r_bzero <= (B == '0);
                        r_busy  <= 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                        r_neg_q <= A[n-1] ^ B[n-1];
                        r_neg_r <= A[n-1];
`endif
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc;
                    r_dvd <= w_q_mag;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_q       <= w_q_fin;
                        r_r       <= w_r_fin;
                        r_divzero <= r_bzero;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign DivZero     = r_divzero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (n = 8). Expected results are hand-computed
// for the build selected by SEQ_DIV_SIGNED_EN.
module tb_seq_div;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_zero;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  seq_div #(.n(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (start),
    .A           (a),
    .B           (b),
    .Busy        (busy),
    .Done        (done),
    .Q           (q),
    .R           (r),
    .DivZero     (div_zero),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for Done, counting cycles; cyc = 1 is the cycle after the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Driver: one operation from IDLE, checks latency, results and return to IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string tag);
    int cyc;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 9);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dz"}, div_zero, edz);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "100_7");
    run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, "5_0");
    run_op(8'd6, 8'd3, 8'd2, 8'd0, 1'b0, "6_3");
    run_op(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, "3_10");
    run_op(8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0, "ff_1");
`ifdef SEQ_DIV_SIGNED_EN
    run_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, "m100_7");
    run_op(8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, "100_m7");
    run_op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, "ovf");
    run_op(8'd200, 8'd7, 8'hF8, 8'd0, 1'b0, "m56_7");
    run_op(8'hFF, 8'd16, 8'd0, 8'hFF, 1'b0, "m1_16");
`else
    run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "200_7");
    run_op(8'hFF, 8'd16, 8'd15, 8'd15, 1'b0, "255_16");
    run_op(8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, "128_255");
`endif

    // Start pulsed mid-CALC with other operands is ignored.
    a = 8'd50; b = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_lat", cyc, 9);
    check("ign_q", q, 8);
    check("ign_r", r, 2);
    @(posedge clk); #1;
    check("ign_idle", busy, 0);
    @(posedge clk); #1;
    check("ign_no_queue", busy, 0);

    // Start held high: back-to-back, one result per n+2 cycles.
    a = 8'd20; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd30; b = 8'd4;
    wait_done(cyc);
    check("b2b_lat1", cyc, 9);
    check("b2b_q1", q, 6);
    check("b2b_r1", r, 2);
    @(posedge clk); #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("b2b_period", cyc, 10);
    check("b2b_q2", q, 7);
    check("b2b_r2", r, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    a = 8'd77; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_r", r, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, "9_2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
